// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - opcodes, FSM states and flag indices for arith_unit_seq
package arith_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_ADC  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_SBB  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_CMP  = 3'b110;
    localparam logic [2:0] OP_CLRF = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - shift-add unsigned multiplier, one iteration per clock
module seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);

    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] prod_next;
    logic               last;

    // The counter is allowed to wrap; the terminal count alone ends the run,
    // so WIDTH == 2**CNT_W needs no extra counter bit.
    assign last      = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);

    // product is the value being written on this edge, so the parent can
    // capture it on the same edge that completes the final iteration.
    assign busy    = busy_q;
    assign done    = last;
    assign product = prod_next;

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        if (busy_q) begin
            prod_d   = prod_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (last) begin
                busy_d = 1'b0;
            end
        end else if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            prod_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

endmodule

// File: rtl/arith_unit_seq.sv
// rtl/arith_unit_seq.sv - registered add/sub/mul accumulator with C/Z/N/V flags and valid/ready
module arith_unit_seq
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             iClock,
    input  logic             iReset,
    input  logic             iValid,
    output logic             oReady,
    input  logic [2:0]       iOpcode,
    input  logic [WIDTH-1:0] iPortA,
    input  logic [WIDTH-1:0] iPortB,
    output logic [WIDTH-1:0] oAccumulator,
    output logic             oDone,
    output logic             oCarryFlag,
    output logic             oZeroFlag,
    output logic             oNegFlag,
    output logic             oOvfFlag
);

    localparam int MSB = WIDTH - 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [3:0]       flags_q, flags_d;
    logic             done_q, done_d;

    logic             accept;
    logic             cin;
    logic [WIDTH:0]   add_res;
    logic [WIDTH:0]   sub_res;
    logic             add_v;
    logic             sub_v;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [2*WIDTH-1:0] mul_product;

    assign accept = iValid && (state_q == ST_IDLE);

    // Carry-in uses the flag held before the accept edge.
    assign cin     = ((iOpcode == OP_ADC) || (iOpcode == OP_SBB)) ? flags_q[FLAG_C] : 1'b0;
    assign add_res = {1'b0, iPortA} + {1'b0, iPortB} + {{WIDTH{1'b0}}, cin};
    // Bit WIDTH of the widened difference is the unsigned borrow.
    assign sub_res = {1'b0, iPortA} - {1'b0, iPortB} - {{WIDTH{1'b0}}, cin};
    assign add_v   = (iPortA[MSB] == iPortB[MSB]) && (add_res[MSB] != iPortA[MSB]);
    assign sub_v   = (iPortA[MSB] != iPortB[MSB]) && (sub_res[MSB] != iPortA[MSB]);

    assign mul_start = accept && (iOpcode == OP_MUL);

    seq_multiplier #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (iClock),
        .rst    (iReset),
        .start  (mul_start),
        .a      (iPortA),
        .b      (iPortB),
        .busy   (mul_busy),
        .done   (mul_done),
        .product(mul_product)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        flags_d = flags_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    done_d = 1'b1;
                    case (iOpcode)
                        OP_ADD, OP_ADC: begin
                            acc_d           = add_res[WIDTH-1:0];
                            flags_d[FLAG_C] = add_res[WIDTH];
                            flags_d[FLAG_Z] = (add_res[WIDTH-1:0] == '0);
                            flags_d[FLAG_N] = add_res[MSB];
                            flags_d[FLAG_V] = add_v;
                        end
                        OP_SUB, OP_SBB, OP_CMP: begin
                            if (iOpcode != OP_CMP) begin
                                acc_d = sub_res[WIDTH-1:0];
                            end
                            flags_d[FLAG_C] = sub_res[WIDTH];
                            flags_d[FLAG_Z] = (sub_res[WIDTH-1:0] == '0);
                            flags_d[FLAG_N] = sub_res[MSB];
                            flags_d[FLAG_V] = sub_v;
                        end
                        OP_MUL: begin
                            done_d  = 1'b0;
                            state_d = ST_MUL;
                        end
                        OP_CLRF: begin
                            flags_d = '0;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    acc_d           = mul_product[WIDTH-1:0];
                    flags_d[FLAG_C] = (mul_product[2*WIDTH-1:WIDTH] != '0);
                    flags_d[FLAG_Z] = (mul_product[WIDTH-1:0] == '0);
                    flags_d[FLAG_N] = mul_product[MSB];
                    flags_d[FLAG_V] = 1'b0;
                    done_d          = 1'b1;
                    state_d         = ST_IDLE;
                end else if (!mul_busy) begin
                    // Multiplier idle while we wait on it: recover without a result.
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            flags_q <= flags_d;
            done_q  <= done_d;
        end
    end

    assign oReady       = (state_q == ST_IDLE);
    assign oAccumulator = acc_q;
    assign oDone        = done_q;
    assign oCarryFlag   = flags_q[FLAG_C];
    assign oZeroFlag    = flags_q[FLAG_Z];
    assign oNegFlag     = flags_q[FLAG_N];
    assign oOvfFlag     = flags_q[FLAG_V];

endmodule

// File: tb/tb_arith_unit_seq.sv
// tb/tb_arith_unit_seq.sv - table-driven self-checking bench for arith_unit_seq
module tb_arith_unit_seq;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        ready;
    logic [2:0]  opcode;
    logic [15:0] port_a;
    logic [15:0] port_b;
    logic [15:0] acc;
    logic        done;
    logic        c_flag, z_flag, n_flag, v_flag;

    int n_checks;
    int n_fail;

    arith_unit_seq #(
        .WIDTH(16)
    ) dut (
        .iClock      (clk),
        .iReset      (rst),
        .iValid      (valid),
        .oReady      (ready),
        .iOpcode     (opcode),
        .iPortA      (port_a),
        .iPortB      (port_b),
        .oAccumulator(acc),
        .oDone       (done),
        .oCarryFlag  (c_flag),
        .oZeroFlag   (z_flag),
        .oNegFlag    (n_flag),
        .oOvfFlag    (v_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_acc;
        logic [3:0]  exp_flg;   // {C,Z,N,V}
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] flg();
        return {c_flag, z_flag, n_flag, v_flag};
    endfunction

    // Offer one operation for a single cycle; returns #1 after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        valid  = 1'b1;
        opcode = op;
        port_a = a;
        port_b = b;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    int cyc;
    int busy_cycles;
    int acc_moved;
    int late_done;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst    = 1'b1;
        valid  = 1'b0;
        opcode = 3'b000;
        port_a = '0;
        port_b = '0;

        vecs[0] = '{3'b001, 16'hFFFF, 16'h0001, 16'h0000, 4'b1100};  // ADD wrap
        vecs[1] = '{3'b010, 16'h0001, 16'h0001, 16'h0003, 4'b0000};  // ADC with C=1
        vecs[2] = '{3'b011, 16'h0003, 16'h0005, 16'hFFFE, 4'b1010};  // SUB borrow
        vecs[3] = '{3'b100, 16'h0010, 16'h0001, 16'h000E, 4'b0000};  // SBB with C=1
        vecs[4] = '{3'b110, 16'h0005, 16'h0005, 16'h000E, 4'b0100};  // CMP equal
        vecs[5] = '{3'b001, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011};  // ADD overflow
        vecs[6] = '{3'b000, 16'h1234, 16'h5678, 16'h8000, 4'b0011};  // NOP holds
        vecs[7] = '{3'b011, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001};  // SUB overflow
        vecs[8] = '{3'b111, 16'hAAAA, 16'h5555, 16'h7FFF, 4'b0000};  // CLRF
        vecs[9] = '{3'b010, 16'h00FF, 16'h0001, 16'h0100, 4'b0000};  // ADC with C=0

        repeat (2) @(posedge clk);
        #1;
        check("reset_acc",   32'(acc),   32'h0);
        check("reset_flags", 32'(flg()), 32'h0);
        check("reset_done",  32'(done),  32'h0);
        check("reset_ready", 32'(ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_done", i),  32'(done),  32'h1);
            check($sformatf("vec%0d_acc", i),   32'(acc),   32'(vecs[i].exp_acc));
            check($sformatf("vec%0d_flags", i), 32'(flg()), 32'(vecs[i].exp_flg));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_done_once", i), 32'(done), 32'h0);
        end

        // MUL 0123*0010, operands disturbed after the accept edge.
        issue(3'b101, 16'h0123, 16'h0010);
        port_a = 16'hFFFF;
        port_b = 16'hFFFF;
        cyc = 0;
        busy_cycles = 0;
        while (!done && cyc < 40) begin
            if (!ready) busy_cycles++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("mul1_latency",     32'(cyc),         32'd16);
        check("mul1_ready_low",   32'(busy_cycles), 32'd16);
        check("mul1_done",        32'(done),        32'h1);
        check("mul1_ready_final", 32'(ready),       32'h1);
        check("mul1_acc",         32'(acc),         32'h1230);
        check("mul1_flags",       32'(flg()),       32'h0);
        @(posedge clk);
        #1;
        check("mul1_done_once", 32'(done), 32'h0);

        // MUL 8000*0002 with an ADD offered throughout; the ADD is taken only
        // in the MUL's done cycle.
        issue(3'b101, 16'h8000, 16'h0002);
        valid  = 1'b1;
        opcode = 3'b001;
        port_a = 16'h0001;
        port_b = 16'h0001;
        cyc = 0;
        acc_moved = 0;
        while (!done && cyc < 40) begin
            if (acc !== 16'h1230) acc_moved++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("mul2_latency",   32'(cyc),       32'd16);
        check("mul2_ignored",   32'(acc_moved), 32'd0);
        check("mul2_acc",       32'(acc),       32'h0000);
        check("mul2_flags",     32'(flg()),     32'hC);
        @(posedge clk);
        #1;
        valid = 1'b0;
        check("b2b_done",  32'(done),  32'h1);
        check("b2b_acc",   32'(acc),   32'h0002);
        check("b2b_flags", 32'(flg()), 32'h0);
        check("b2b_ready", 32'(ready), 32'h1);

        // Reset in the middle of a MUL.
        issue(3'b001, 16'h7FFF, 16'h0001);
        check("pre_rst_acc", 32'(acc), 32'h8000);
        issue(3'b101, 16'h0003, 16'h0003);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_acc",   32'(acc),   32'h0);
        check("midrst_flags", 32'(flg()), 32'h0);
        check("midrst_done",  32'(done),  32'h0);
        check("midrst_ready", 32'(ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        late_done = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done) late_done++;
        end
        check("midrst_no_late_done", 32'(late_done), 32'd0);
        check("midrst_acc_hold",     32'(acc),       32'h0);

        issue(3'b001, 16'h0002, 16'h0003);
        check("post_rst_acc",   32'(acc),   32'h0005);
        check("post_rst_flags", 32'(flg()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
